// File: rtl/dht11_capture_sched.sv
// DHT11 capture scheduler: merges manual and periodic requests into one
// drv_start stream, enforces the sensor holdoff, and retries on timeout/error.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   ms_tick                1 ms strobe
//   manual_req             debounced level, rising edge requests a capture
//   auto_en, auto_period_s periodic capture enable and interval (s, 0=off)
//   drv_start              one-clk start pulse to the sensor driver
//   drv_done, drv_err      driver completion strobe and its error flag
//   drv_humid, drv_temp    driver data, valid with drv_done
//   humid, temp, valid     last good reading and "have one" flag
//   busy, fail             not idle / last request exhausted its retries
//   err_cnt                saturating failed-attempt counter
//
// Build option: define DHT_SCHED_ERRCNT_EN to build the err_cnt counter;
// otherwise err_cnt is tied to 0.

module dht11_capture_sched #(
    parameter int HOLDOFF_MS  = 2000,
    parameter int TIMEOUT_MS  = 50,
    parameter int MAX_RETRY   = 2,
    parameter int TICKS_PER_S = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms_tick,
    input  logic       manual_req,
    input  logic       auto_en,
    input  logic [3:0] auto_period_s,
    output logic       drv_start,
    input  logic       drv_done,
    input  logic       drv_err,
    input  logic [7:0] drv_humid,
    input  logic [7:0] drv_temp,
    output logic [7:0] humid,
    output logic [7:0] temp,
    output logic       valid,
    output logic       busy,
    output logic       fail,
    output logic [7:0] err_cnt
);

    localparam int TMAX = (HOLDOFF_MS > TIMEOUT_MS) ? HOLDOFF_MS : TIMEOUT_MS;
    localparam int TW   = $clog2(TMAX + 2);
    localparam int PW   = $clog2(TICKS_PER_S + 2);

    localparam logic [TW-1:0] HOLD_LIM  = TW'(HOLDOFF_MS);
    localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_MS);
    localparam logic [PW-1:0] PRE_LIM   = PW'(TICKS_PER_S);
    localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_start;
    logic          r_man_q;
    logic          r_pend;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_sec;
    logic [TW-1:0] r_tmr;
    logic [2:0]    r_retry;
    logic          r_rpend;
    logic [7:0]    r_humid;
    logic [7:0]    r_temp;
    logic          r_valid;
    logic          r_fail;

    logic          w_auto_on;
    logic [PW-1:0] w_pre_inc;
    logic          w_pre_wrap;
    logic [3:0]    w_sec_inc;
    logic          w_sec_hit;
    logic          w_auto_req;
    logic          w_man_rise;
    logic          w_req;
    logic [TW-1:0] w_tmr_inc;
    logic          w_tmo;
    logic          w_hold_done;
    logic          w_good;
    logic          w_bad;

    // Request sources
    assign w_auto_on  = auto_en & (auto_period_s != 4'd0);
    assign w_pre_inc  = r_pre + 1'b1;
    assign w_pre_wrap = (w_pre_inc >= PRE_LIM);
    assign w_sec_inc  = r_sec + 1'b1;
    assign w_sec_hit  = (w_sec_inc >= auto_period_s);
    assign w_auto_req = w_auto_on & ms_tick & w_pre_wrap & w_sec_hit;
    assign w_man_rise = manual_req & ~r_man_q;
    assign w_req      = w_man_rise | w_auto_req;

    // Limits are tested against the post-increment value on a tick, so a
    // limit of 0 or 1 still takes exactly one tick.
    assign w_tmr_inc   = r_tmr + 1'b1;
    assign w_tmo       = ms_tick & (w_tmr_inc >= TMO_LIM);
    assign w_hold_done = ms_tick & (w_tmr_inc >= HOLD_LIM);

    // drv_done beats a coincident timeout
    assign w_good = (r_state == S_WAIT) & drv_done & ~drv_err;
    assign w_bad  = (r_state == S_WAIT) & (drv_done ? drv_err : w_tmo);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (r_pend) w_state_nx = S_START;
            S_START: w_state_nx = S_WAIT;
            S_WAIT:  if (drv_done | w_tmo) w_state_nx = S_HOLD;
            S_HOLD: begin
                if (w_hold_done)
                    w_state_nx = (r_rpend | r_pend) ? S_START : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // drv_start comes straight from a flop so it cannot glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_start <= (w_state_nx == S_START);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_man_q <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_man_q <= manual_req;
            // a request landing in START stays queued for the next round
            r_pend  <= w_req | (r_pend & (r_state != S_START));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (!w_auto_on) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (ms_tick) begin
            if (w_pre_wrap) begin
                r_pre <= '0;
                r_sec <= w_sec_hit ? 4'd0 : w_sec_inc;
            end else begin
                r_pre <= w_pre_inc;
            end
        end
    end

    // One timer shared by WAIT and HOLD, cleared on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (w_state_nx != r_state) begin
            r_tmr <= '0;
        end else if (ms_tick &&
                     (r_state == S_WAIT || r_state == S_HOLD)) begin
            r_tmr <= w_tmr_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_humid <= '0;
            r_temp  <= '0;
            r_valid <= 1'b0;
            r_fail  <= 1'b0;
            r_retry <= '0;
            r_rpend <= 1'b0;
        end else if (w_good) begin
            r_humid <= drv_humid;
            r_temp  <= drv_temp;
            r_valid <= 1'b1;
            r_fail  <= 1'b0;
            r_retry <= '0;
            r_rpend <= 1'b0;
        end else if (w_bad) begin
            if (r_retry < RETRY_LIM) begin
                r_retry <= r_retry + 1'b1;
                r_rpend <= 1'b1;
            end else begin
                r_fail  <= 1'b1;
                r_retry <= '0;
                r_rpend <= 1'b0;
            end
        end else if (r_state == S_START) begin
            r_rpend <= 1'b0;
        end
    end

`ifdef DHT_SCHED_ERRCNT_EN
    logic [7:0] r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else if (w_bad && r_err != 8'hFF) begin
            r_err <= r_err + 1'b1;
        end
    end

    assign err_cnt = r_err;
`else
    assign err_cnt = 8'd0;
`endif

    assign drv_start = r_start;
    assign humid     = r_humid;
    assign temp      = r_temp;
    assign valid     = r_valid;
    assign fail      = r_fail;
    assign busy      = (r_state != S_IDLE);

endmodule
